// File: rtl/mp_arith_pkg.sv
// Shared definitions for the word-serial modular add/subtract engine:
// FSM encoding, operation and load-select codes, default geometry.
package mp_arith_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] LD_A = 2'b00;
  localparam logic [1:0] LD_B = 2'b01;
  localparam logic [1:0] LD_P = 2'b10;

endpackage

// File: rtl/mp_word_shreg.sv
// Cyclic word bank: LSW leaves at index 0; MSW slot takes either the load word
// (load-shift) or the outgoing LSW (rotate). Contents are deliberately not reset.
module mp_word_shreg
  import mp_arith_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              clk,
  input  logic              ld_en_i,
  input  logic              rot_en_i,
  input  logic [WORD_W-1:0] din_i,
  output logic [WORD_W-1:0] lsw_o
);

  logic [WORD_W-1:0] mem_q [NWORDS];
  logic [WORD_W-1:0] mem_d [NWORDS];

  // Shift toward the LSW; load has priority over rotate at the MSW slot
  always_comb begin
    for (int k = 0; k < NWORDS - 1; k++) begin
      mem_d[k] = mem_q[k+1];
    end
    if (ld_en_i) begin
      mem_d[NWORDS-1] = din_i;
    end else begin
      mem_d[NWORDS-1] = mem_q[0];
    end
  end

  // Bank storage
  always_ff @(posedge clk) begin
    if (ld_en_i || rot_en_i) begin
      mem_q <= mem_d;
    end
  end

  assign lsw_o = mem_q[0];

endmodule

// File: rtl/mp_modaddsub_engine.sv
// Word-serial modular add/subtract: pass 1 forms A+/-B, pass 2 corrects by P, FIN selects.
// Optional result==1 detection is built when MPAS_ONE_DETECT_EN is defined.
module mp_modaddsub_engine
  import mp_arith_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [1:0]        ld_sel,
  input  logic [WORD_W-1:0] datain,
  input  logic              start,
  input  logic              op,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dataout,
  output logic              is_one
);

  localparam int               CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              c1_q, c1_d;
  logic              op_q, op_d;
  logic              res_sel_q, res_sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] dataout_q, dataout_d;

  logic              a_ld, a_rot, b_ld, b_rot, p_ld, p_rot;
  logic              s_ld, s_rot, t_ld, t_rot;
  logic [WORD_W-1:0] a_lsw, b_lsw, p_lsw, s_lsw, t_lsw;

  logic              pass1;
  logic [WORD_W-1:0] add_x, add_y;
  logic              add_cin;
  logic [WORD_W:0]   sum;

  // Shared word adder: pass 1 uses A and (inverted for subtract) B, pass 2 uses S and P
  always_comb begin
    pass1 = (state_q == ST_PASS1);
    if (pass1) begin
      add_x = a_lsw;
      add_y = b_lsw ^ {WORD_W{op_q}};
    end else begin
      add_x = s_lsw;
      add_y = p_lsw ^ {WORD_W{~op_q}};
    end
    if (cnt_q == '0) begin
      add_cin = pass1 ? (op_q == OP_SUB) : (op_q == OP_ADD);
    end else begin
      add_cin = carry_q;
    end
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WORD_W{1'b0}}, add_cin};
  end

`ifdef MPAS_ONE_DETECT_EN
  logic s_one_q, s_one_d, t_one_q, t_one_d, is_one_q, is_one_d;
  logic word_match;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    c1_d      = c1_q;
    op_d      = op_q;
    res_sel_d = res_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dataout_d = dataout_q;
    a_ld = 1'b0; a_rot = 1'b0; b_ld = 1'b0; b_rot = 1'b0; p_ld = 1'b0; p_rot = 1'b0;
    s_ld = 1'b0; s_rot = 1'b0; t_ld = 1'b0; t_rot = 1'b0;
`ifdef MPAS_ONE_DETECT_EN
    s_one_d    = s_one_q;
    t_one_d    = t_one_q;
    is_one_d   = is_one_q;
    word_match = (cnt_q == '0) ? (sum[WORD_W-1:0] == WORD_W'(1)) : (sum[WORD_W-1:0] == '0);
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_we) begin
          case (ld_sel)
            LD_A:    a_ld = 1'b1;
            LD_B:    b_ld = 1'b1;
            LD_P:    p_ld = 1'b1;
            default: a_ld = 1'b0;
          endcase
        end else begin
          a_ld = 1'b0;
        end
        if (rd_en) begin
          dataout_d = res_sel_q ? t_lsw : s_lsw;
          t_rot     = res_sel_q;
          s_rot     = ~res_sel_q;
        end else begin
          dataout_d = dataout_q;
        end
        if (start) begin
          state_d = ST_PASS1;
          op_d    = op;
          cnt_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
`ifdef MPAS_ONE_DETECT_EN
          is_one_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS1: begin
        a_rot   = 1'b1;
        b_rot   = 1'b1;
        s_ld    = 1'b1;
        carry_d = sum[WORD_W];
`ifdef MPAS_ONE_DETECT_EN
        s_one_d = word_match & ((cnt_q == '0) | s_one_q);
`endif
        if (cnt_q == CNT_LAST) begin
          c1_d    = sum[WORD_W];
          cnt_d   = '0;
          state_d = ST_PASS2;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_PASS2: begin
        s_rot   = 1'b1;
        p_rot   = 1'b1;
        t_ld    = 1'b1;
        carry_d = sum[WORD_W];
`ifdef MPAS_ONE_DETECT_EN
        t_one_d = word_match & ((cnt_q == '0) | t_one_q);
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        // carry_q now holds the pass-2 final carry (c2)
        res_sel_d = (op_q == OP_ADD) ? (c1_q | carry_q) : ~c1_q;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
`ifdef MPAS_ONE_DETECT_EN
        is_one_d  = res_sel_d ? t_one_q : s_one_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      op_q      <= 1'b0;
      res_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dataout_q <= '0;
`ifdef MPAS_ONE_DETECT_EN
      s_one_q   <= 1'b0;
      t_one_q   <= 1'b0;
      is_one_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      c1_q      <= c1_d;
      op_q      <= op_d;
      res_sel_q <= res_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
`ifdef MPAS_ONE_DETECT_EN
      s_one_q   <= s_one_d;
      t_one_q   <= t_one_d;
      is_one_q  <= is_one_d;
`endif
    end
  end

  mp_word_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_bank_a (
    .clk(clk), .ld_en_i(a_ld), .rot_en_i(a_rot), .din_i(datain), .lsw_o(a_lsw));
  mp_word_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_bank_b (
    .clk(clk), .ld_en_i(b_ld), .rot_en_i(b_rot), .din_i(datain), .lsw_o(b_lsw));
  mp_word_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_bank_p (
    .clk(clk), .ld_en_i(p_ld), .rot_en_i(p_rot), .din_i(datain), .lsw_o(p_lsw));
  mp_word_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_bank_s (
    .clk(clk), .ld_en_i(s_ld), .rot_en_i(s_rot), .din_i(sum[WORD_W-1:0]), .lsw_o(s_lsw));
  mp_word_shreg #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_bank_t (
    .clk(clk), .ld_en_i(t_ld), .rot_en_i(t_rot), .din_i(sum[WORD_W-1:0]), .lsw_o(t_lsw));

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataout = dataout_q;
`ifdef MPAS_ONE_DETECT_EN
  assign is_one  = is_one_q;
`else
  assign is_one  = 1'b0;
`endif

endmodule

// File: tb/tb_mp_modaddsub_engine.sv
// Directed bench for mp_modaddsub_engine at WORD_W=8, NWORDS=2: vector table plus
// protocol, busy-ignore and mid-operation reset sequences.
module tb_mp_modaddsub_engine;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld_we = 1'b0;
  logic [1:0]   ld_sel = 2'b00;
  logic [W-1:0] datain = '0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         busy, done, rd_en, is_one;
  logic [W-1:0] dataout;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        op;
    logic [15:0] p;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        one;
  } vec_t;

  vec_t vecs[6];

  mp_modaddsub_engine #(.WORD_W(W), .NWORDS(N)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_sel(ld_sel), .datain(datain),
    .start(start), .op(op), .busy(busy), .done(done), .rd_en(rd_en),
    .dataout(dataout), .is_one(is_one));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [1:0] sel, input logic [15:0] val);
    ld_we  = 1'b1;
    ld_sel = sel;
    datain = val[7:0];
    tick();
    datain = val[15:8];
    tick();
    ld_we  = 1'b0;
  endtask

  task automatic load_ops(input logic [15:0] p, input logic [15:0] a, input logic [15:0] b);
    load_val(2'b10, p);
    load_val(2'b00, a);
    load_val(2'b01, b);
  endtask

  // Starts an operation (already loaded) and waits for done with a cycle bound.
  task automatic run_op(input logic o, input string tag);
    int n;
    start = 1'b1;
    op    = o;
    tick();
    start = 1'b0;
    op    = 1'b0;
    n     = 1;
    check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 32'd6);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic read_res(output logic [15:0] r);
    rd_en = 1'b1;
    tick();
    r[7:0] = dataout;
    tick();
    r[15:8] = dataout;
    rd_en = 1'b0;
  endtask

  logic [15:0] res;
  logic        exp_one;
  logic [W-1:0] prev;
  int          n;
  int          done_seen;

  initial begin
    rd_en = 1'b0;
    vecs[0] = '{1'b0, 16'h00FB, 16'h00F0, 16'h0005, 16'h00F5, 1'b0};
    vecs[1] = '{1'b0, 16'h00FB, 16'h00FA, 16'h0003, 16'h0002, 1'b0};
    vecs[2] = '{1'b0, 16'h00FB, 16'h00FA, 16'h0002, 16'h0001, 1'b1};
    vecs[3] = '{1'b0, 16'hFFF1, 16'hFFF0, 16'hFFF0, 16'hFFEF, 1'b0};
    vecs[4] = '{1'b1, 16'h00FB, 16'h0010, 16'h0003, 16'h000D, 1'b0};
    vecs[5] = '{1'b1, 16'h00FB, 16'h0003, 16'h0010, 16'h00EE, 1'b0};

    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dataout", {24'd0, dataout}, 32'd0);
    check("reset is_one", {31'd0, is_one}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      load_ops(vecs[i].p, vecs[i].a, vecs[i].b);
      // reserved bank select must not disturb anything
      ld_we = 1'b1; ld_sel = 2'b11; datain = 8'hAA;
      tick();
      ld_we = 1'b0;
      run_op(vecs[i].op, $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d done_pulse", i), {31'd0, done}, 32'd0);
      read_res(res);
      check($sformatf("vec%0d result", i), {16'd0, res}, {16'd0, vecs[i].r});
`ifdef MPAS_ONE_DETECT_EN
      exp_one = vecs[i].one;
`else
      exp_one = 1'b0;
`endif
      check($sformatf("vec%0d is_one", i), {31'd0, is_one}, {31'd0, exp_one});
    end

    // Inputs pulsed while busy are ignored
    load_ops(16'h00FB, 16'h00F0, 16'h0005);
    prev  = dataout;
    start = 1'b1; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 1'b1; ld_we = 1'b1; ld_sel = 2'b00; datain = 8'h77; rd_en = 1'b1;
    tick();
    start = 1'b0; op = 1'b0; ld_we = 1'b0; rd_en = 1'b0;
    check("busy rd ignored", {24'd0, dataout}, {24'd0, prev});
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("busy latency", n, 32'd6);
    tick();
    read_res(res);
    check("busy result", {16'd0, res}, 32'h00F5);
    // A must still be intact: rerun gives the same result
    run_op(1'b0, "rerun");
    rd_en = 1'b1;
    tick();
    check("read1", {24'd0, dataout}, 32'hF5);
    tick();
    check("read2", {24'd0, dataout}, 32'h00);
    tick();
    check("read3 wrap", {24'd0, dataout}, 32'hF5);
    rd_en = 1'b0;

    // Reset during PASS2
    start = 1'b1; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) done_seen++;
    end
    check("rst no done", done_seen, 32'd0);

    // Reload; final A word loaded in the same cycle start is accepted
    load_val(2'b10, 16'h00FB);
    load_val(2'b01, 16'h0005);
    ld_we = 1'b1; ld_sel = 2'b00; datain = 8'hF0;
    tick();
    datain = 8'h00; start = 1'b1; op = 1'b0;
    tick();
    ld_we = 1'b0; start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("after rst latency", n, 32'd6);
    tick();
    read_res(res);
    check("after rst result", {16'd0, res}, 32'h00F5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
